bypass_scoreboard: RTL and testbench

//  Parametrised operand-forwarding and hazard unit between decode and the DX latch. Tracks the
//  in-flight destination registers of the last DEPTH issued instructions (X, M, W, ...).

---
 rtl/bypass_scoreboard.sv | 121 ++++++++++++
 tb/tb_bypass_scoreboard.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bypass_scoreboard.sv
// Operand-forwarding and load-use hazard unit between decode and the DX latch.
// Tracks the destinations of the last DEPTH issued instructions and picks the youngest ready producer.
module bypass_scoreboard #(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDR_WIDTH       = 5,
  parameter int NUM_READ         = 2,
  parameter int DEPTH            = 3,
  parameter int LOAD_READY_STAGE = 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           issue_valid,
  input  logic                           issue_we,
  input  logic [ADDR_WIDTH-1:0]          issue_rd,
  input  logic                           issue_is_load,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr,
  input  logic [NUM_READ*DATA_WIDTH-1:0] rf_data,
  input  logic [DEPTH*DATA_WIDTH-1:0]    stage_data,
  input  logic                           flush,
  output logic                           stall,
  output logic [NUM_READ*DATA_WIDTH-1:0] op_data,
  output logic                           op_valid,
  output logic [31:0]                    stall_cycles
);

  localparam int RW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]                 v_q, v_d;
  logic [DEPTH-1:0]                 we_q, we_d;
  logic [DEPTH-1:0][ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [DEPTH-1:0][RW-1:0]         rdy_q, rdy_d;
  logic [NUM_READ*DATA_WIDTH-1:0]   op_data_q, op_data_d;
  logic                             op_valid_q, op_valid_d;
  logic [31:0]                      stall_cycles_q, stall_cycles_d;

  logic [NUM_READ*DATA_WIDTH-1:0]   fwd;
  logic [NUM_READ-1:0]              hazard;
  logic                             advance;

  // Only the youngest matching producer decides; older matches never override it.
  always_comb begin
    fwd    = '0;
    hazard = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      logic [ADDR_WIDTH-1:0] addr;
      logic                  found;
      logic [DATA_WIDTH-1:0] val;
      addr  = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      found = 1'b0;
      val   = rf_data[p*DATA_WIDTH +: DATA_WIDTH];
      for (int s = 0; s < DEPTH; s++) begin
        if (!found && v_q[s] && we_q[s] && (rd_q[s] == addr)) begin
          found = 1'b1;
          if (s >= int'(rdy_q[s])) val = stage_data[s*DATA_WIDTH +: DATA_WIDTH];
          else hazard[p] = 1'b1;
        end
      end
      if (addr == '0) begin
        val       = '0;
        hazard[p] = 1'b0;
      end
      fwd[p*DATA_WIDTH +: DATA_WIDTH] = val;
    end
  end

  assign stall   = issue_valid & ~flush & (|hazard);
  assign advance = issue_valid & ~stall & ~flush;

  // Entries shift every cycle, stalled or not, so a pending load drains into a ready stage.
  always_comb begin
    v_d            = '0;
    we_d           = '0;
    rd_d           = '0;
    rdy_d          = '0;
    op_data_d      = op_data_q;
    op_valid_d     = 1'b0;
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) stall_cycles_d = stall_cycles_q + 32'd1;
    if (!flush) begin
      for (int s = 1; s < DEPTH; s++) begin
        v_d[s]   = v_q[s-1];
        we_d[s]  = we_q[s-1];
        rd_d[s]  = rd_q[s-1];
        rdy_d[s] = rdy_q[s-1];
      end
      if (advance) begin
        v_d[0]     = 1'b1;
        we_d[0]    = issue_we;
        rd_d[0]    = issue_rd;
        rdy_d[0]   = issue_is_load ? RW'(LOAD_READY_STAGE) : '0;
        op_data_d  = fwd;
        op_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      v_q            <= '0;
      we_q           <= '0;
      rd_q           <= '0;
      rdy_q          <= '0;
      op_data_q      <= '0;
      op_valid_q     <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      v_q            <= v_d;
      we_q           <= we_d;
      rd_q           <= rd_d;
      rdy_q          <= rdy_d;
      op_data_q      <= op_data_d;
      op_valid_q     <= op_valid_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign op_data      = op_data_q;
  assign op_valid     = op_valid_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_bypass_scoreboard.sv
// Self-checking bench for bypass_scoreboard: directed vector table, hand sequences,
// and randomized traffic compared against an instruction-level reference model.
module tb_bypass_scoreboard;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NR  = 2;
  localparam int D   = 3;
  localparam int LRS = 1;

  logic             clock;
  logic             reset;
  logic             issue_valid;
  logic             issue_we;
  logic [AW-1:0]    issue_rd;
  logic             issue_is_load;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rf_data;
  logic [D*DW-1:0]  stage_data;
  logic             flush;
  logic             stall;
  logic [NR*DW-1:0] op_data;
  logic             op_valid;
  logic [31:0]      stall_cycles;

  bypass_scoreboard #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .DEPTH(D), .LOAD_READY_STAGE(LRS)
  ) dut (
    .clock(clock), .reset(reset), .issue_valid(issue_valid), .issue_we(issue_we),
    .issue_rd(issue_rd), .issue_is_load(issue_is_load), .rd_addr(rd_addr),
    .rf_data(rf_data), .stage_data(stage_data), .flush(flush), .stall(stall),
    .op_data(op_data), .op_valid(op_valid), .stall_cycles(stall_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // An in-flight instruction as the pipeline sees it; index = age in cycles since issue.
  typedef struct {
    bit            valid;
    bit            writes;
    logic [AW-1:0] dest;
    bit            is_load;
  } instr_t;

  instr_t        pipe [D];
  logic [DW-1:0] m_op [NR];
  bit            m_opv;
  logic [31:0]   m_cnt;

  typedef struct {
    bit          iv, we, ld, fl;
    logic [4:0]  rd, a0, a1;
    logic [31:0] sd0, sd1, sd2, rf0, rf1;
    bit          exp_stall, exp_opv;
    logic [31:0] exp_op0, exp_op1, exp_cnt;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int s = 0; s < D; s++) pipe[s] = '{0, 0, '0, 0};
    for (int p = 0; p < NR; p++) m_op[p] = '0;
    m_opv = 0;
    m_cnt = '0;
  endfunction

  // Drive one cycle, check stall before the edge against the model, then the registered outputs after it.
  task automatic applyStimulus(input bit iv, input bit we, input logic [4:0] rd, input bit ld,
                               input logic [4:0] a0, input logic [4:0] a1,
                               input logic [31:0] sd0, input logic [31:0] sd1, input logic [31:0] sd2,
                               input logic [31:0] rf0, input logic [31:0] rf1,
                               input bit fl, input bit rst, output logic stall_seen);
    logic [4:0]    addr [NR];
    logic [31:0]   sd [D];
    logic [31:0]   rf [NR];
    logic [DW-1:0] want [NR];
    bit            haz, e_stall, adv;
    issue_valid = iv; issue_we = we; issue_rd = rd; issue_is_load = ld;
    rd_addr = {a1, a0}; rf_data = {rf1, rf0}; stage_data = {sd2, sd1, sd0};
    flush = fl; reset = rst;
    addr[0] = a0; addr[1] = a1; rf[0] = rf0; rf[1] = rf1;
    sd[0] = sd0; sd[1] = sd1; sd[2] = sd2;
    haz = 0;
    for (int p = 0; p < NR; p++) begin
      want[p] = rf[p];
      if (addr[p] == 0) want[p] = '0;
      else begin
        for (int age = 0; age < D; age++) begin
          if (pipe[age].valid && pipe[age].writes && pipe[age].dest == addr[p]) begin
            if (age >= (pipe[age].is_load ? LRS : 0)) want[p] = sd[age];
            else haz = 1;
            break;
          end
        end
      end
    end
    e_stall = iv && !fl && haz;
    adv     = iv && !e_stall && !fl;
    #1;
    check("stall", {31'b0, stall}, {31'b0, e_stall});
    stall_seen = stall;
    @(posedge clock);
    if (rst) model_reset();
    else begin
      if (e_stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (fl) begin
        for (int s = 0; s < D; s++) pipe[s] = '{0, 0, '0, 0};
        m_opv = 0;
      end else begin
        for (int s = D - 1; s > 0; s--) pipe[s] = pipe[s-1];
        if (adv) begin
          pipe[0] = '{1, we, rd, ld};
          for (int p = 0; p < NR; p++) m_op[p] = want[p];
        end else pipe[0] = '{0, 0, '0, 0};
        m_opv = adv;
      end
    end
    #1;
    check("op_data0", op_data[0 +: DW], m_op[0]);
    check("op_data1", op_data[DW +: DW], m_op[1]);
    check("op_valid", {31'b0, op_valid}, {31'b0, m_opv});
    check("stall_cycles", stall_cycles, m_cnt);
    @(negedge clock);
  endtask

  task automatic checkOutput(input string name, input vec_t v, input logic stall_seen);
    check({name, ".stall"}, {31'b0, stall_seen}, {31'b0, v.exp_stall});
    check({name, ".op_valid"}, {31'b0, op_valid}, {31'b0, v.exp_opv});
    check({name, ".op0"}, op_data[0 +: DW], v.exp_op0);
    check({name, ".op1"}, op_data[DW +: DW], v.exp_op1);
    check({name, ".cnt"}, stall_cycles, v.exp_cnt);
  endtask

  vec_t vecs [19];

  initial begin
    logic st;
    //        iv we ld fl  rd  a0  a1  sd0    sd1    sd2    rf0     rf1     stall opv op0     op1     cnt
    vecs[0]  = '{1, 1, 0, 0, 3,  0,  0, 32'h0, 32'h0, 32'h0, 32'h0,  32'h0,  0, 1, 32'h0,   32'h0,   0};
    vecs[1]  = '{1, 0, 0, 0, 0,  3,  0, 32'h55,32'h0, 32'h0, 32'h0,  32'h0,  0, 1, 32'h55,  32'h0,   0};
    vecs[2]  = '{1, 1, 1, 0, 4,  0,  0, 32'h0, 32'h0, 32'h0, 32'h0,  32'h0,  0, 1, 32'h0,   32'h0,   0};
    vecs[3]  = '{1, 0, 0, 0, 0,  0,  4, 32'h0, 32'h0, 32'h0, 32'h0,  32'h0,  1, 0, 32'h0,   32'h0,   1};
    vecs[4]  = '{1, 0, 0, 0, 0,  0,  4, 32'h0, 32'h99,32'h0, 32'h0,  32'h0,  0, 1, 32'h0,   32'h99,  1};
    vecs[5]  = '{1, 1, 0, 0, 5,  0,  0, 32'h0, 32'h0, 32'h0, 32'h0,  32'h0,  0, 1, 32'h0,   32'h0,   1};
    vecs[6]  = '{1, 1, 0, 0, 5,  0,  0, 32'h0, 32'h0, 32'h0, 32'h0,  32'h0,  0, 1, 32'h0,   32'h0,   1};
    vecs[7]  = '{1, 0, 0, 0, 0,  5,  0, 32'h1, 32'h2, 32'h0, 32'h0,  32'h0,  0, 1, 32'h1,   32'h0,   1};
    vecs[8]  = '{1, 1, 0, 0, 0,  0,  0, 32'h0, 32'h0, 32'h0, 32'h0,  32'h0,  0, 1, 32'h0,   32'h0,   1};
    vecs[9]  = '{1, 0, 0, 0, 0,  0,  0, 32'hFF,32'h0, 32'h0, 32'h0,  32'h0,  0, 1, 32'h0,   32'h0,   1};
    vecs[10] = '{1, 1, 0, 0, 7,  0,  0, 32'h0, 32'h0, 32'h0, 32'h0,  32'h0,  0, 1, 32'h0,   32'h0,   1};
    vecs[11] = '{1, 0, 0, 0, 0,  0,  0, 32'h0, 32'h0, 32'h0, 32'h0,  32'h0,  0, 1, 32'h0,   32'h0,   1};
    vecs[12] = '{1, 0, 0, 0, 0,  0,  0, 32'h0, 32'h0, 32'h0, 32'h0,  32'h0,  0, 1, 32'h0,   32'h0,   1};
    vecs[13] = '{1, 0, 0, 0, 0,  7,  0, 32'h11,32'h22,32'hAB,32'h0,  32'h0,  0, 1, 32'hAB,  32'h0,   1};
    vecs[14] = '{1, 0, 0, 0, 0,  9, 10, 32'h0, 32'h0, 32'h0, 32'h123,32'h456,0, 1, 32'h123, 32'h456, 1};
    vecs[15] = '{0, 0, 0, 0, 0,  0,  0, 32'h0, 32'h0, 32'h0, 32'h0,  32'h0,  0, 0, 32'h123, 32'h456, 1};
    vecs[16] = '{1, 1, 1, 0, 6,  0,  0, 32'h0, 32'h0, 32'h0, 32'h0,  32'h0,  0, 1, 32'h0,   32'h0,   1};
    vecs[17] = '{1, 0, 0, 1, 0,  6,  0, 32'h0, 32'h0, 32'h0, 32'h0,  32'h0,  0, 0, 32'h0,   32'h0,   1};
    vecs[18] = '{1, 0, 0, 0, 0,  6,  0, 32'hDD,32'hEE,32'h0, 32'h777,32'h0,  0, 1, 32'h777, 32'h0,   1};

    issue_valid = 0; issue_we = 0; issue_rd = '0; issue_is_load = 0;
    rd_addr = '0; rf_data = '0; stage_data = '0; flush = 0; reset = 1;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("reset.op_data", op_data[31:0] | op_data[63:32], 32'h0);
    check("reset.op_valid", {31'b0, op_valid}, 32'h0);
    check("reset.stall_cycles", stall_cycles, 32'h0);
    @(negedge clock);
    reset = 0;

    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].iv, vecs[i].we, vecs[i].rd, vecs[i].ld, vecs[i].a0, vecs[i].a1,
                    vecs[i].sd0, vecs[i].sd1, vecs[i].sd2, vecs[i].rf0, vecs[i].rf1,
                    vecs[i].fl, 0, st);
      checkOutput($sformatf("vec%0d", i), vecs[i], st);
    end

    // Reset arriving while a load-use stall is pending.
    applyStimulus(1, 1, 8, 1, 9, 0, 0, 0, 0, 32'h5A, 0, 0, 0, st);
    check("pre_reset.op0", op_data[0 +: DW], 32'h5A);
    applyStimulus(1, 0, 0, 0, 8, 0, 0, 0, 0, 0, 0, 0, 1, st);
    check("mid_stall.stall_seen", {31'b0, st}, 32'h1);
    check("mid_stall.op0", op_data[0 +: DW], 32'h0);
    check("mid_stall.op_valid", {31'b0, op_valid}, 32'h0);
    check("mid_stall.cnt", stall_cycles, 32'h0);
    applyStimulus(1, 0, 0, 0, 8, 0, 32'h31, 32'h32, 32'h33, 32'h44, 0, 0, 0, st);
    check("after_reset.rf", op_data[0 +: DW], 32'h44);

    for (int c = 0; c < 400; c++) begin
      applyStimulus($urandom_range(0, 9) < 8, 1'($urandom), 5'($urandom_range(0, 3)),
                    1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    $urandom, $urandom, $urandom, $urandom, $urandom,
                    $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0, st);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
